// File: rtl/seq_mult_ctrl.sv
// Purpose : radix-2 shift-add sequential multiplier with start/busy/done handshake.
// Latency : WIDTH cycles from the accepting edge to done; one result per WIDTH+1 cycles back-to-back.
// Backpressure: none; start is ignored while busy, with no queueing and no restart.
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst      asynchronous active-low reset
//   i_clear    synchronous abort: back to IDLE and zero the product
//   i_start    request, sampled only when o_busy=0 (IDLE or DONE)
//   i_a, i_b   unsigned multiplicand / multiplier, captured on the accepting edge
//   o_busy     high while a multiplication is in progress
//   o_done     one-cycle pulse; o_product is valid from the same cycle
//   o_product  last completed result, held until the next completion, clear or reset
module seq_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_p;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_p_next;

    // One shift-add step: the sum keeps its carry bit, which becomes the new
    // MSB of the accumulator after the logical right shift.
    always_comb begin
        w_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]};
        if (r_p[0]) begin
            w_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        end
        w_p_next = {w_sum, r_p[WIDTH-1:1]};
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_p       <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else if (i_clear) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // done is a single-cycle pulse in either case
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_mcand <= i_a;
                        r_p     <= {{WIDTH{1'b0}}, i_b};
                        r_cnt   <= CNT_W'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        // Last step: publish the freshly shifted accumulator.
                        r_product <= w_p_next;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a quiet IDLE.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_product;

endmodule
